// File: rtl/proc_pkg.sv
// proc_pkg: shared constants for the processor control slice.
//   - register file geometry (8 registers, 9-bit data/instruction word)
//   - opcode encodings carried in IR[8:6]
//   - control FSM state encoding
package proc_pkg;

   localparam int NUM_REGS = 8;
   localparam int DATA_W   = 9;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_INC = 3'b100;
   localparam logic [2:0] OP_DEC = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_T1   = 2'b01,
      S_T2   = 2'b10,
      S_T3   = 2'b11
   } state_t;

endpackage

// File: rtl/dec3to8.sv
// dec3to8: 3-bit binary to 8-bit one-hot decoder.
//   sel     in  3  register index
//   onehot  out 8  bit[sel] set, all others clear
module dec3to8 (
   input  logic [2:0] sel,
   output logic [7:0] onehot
);

   // One-hot decode of the register index.
   always_comb begin
      onehot = 8'b0000_0001 << sel;
   end

endmodule

// File: rtl/proc_control.sv
// proc_control: control FSM for a simple multi-cycle processor.
// Sequences IDLE -> T1 [-> T2 -> T3] per instruction; all outputs are a
// combinational decode of the current state and IR.
//   Clock     in   system clock (rising edge)
//   Reset     in   synchronous active-high reset
//   Run       in   start request, sampled only in IDLE
//   IR        in   instruction {opcode, XXX, YYY}
//   IRin      out  IR register load enable
//   Rin       out  one-hot register write enables
//   Rout      out  one-hot register bus selects
//   Gout      out  G bus select
//   DIn_out   out  DIn bus select
//   ones_out  out  constant-ones bus select
//   Ain       out  A load enable
//   Gin       out  G load enable
//   AddSub    out  ALU op (0 add, 1 subtract)
//   Done      out  instruction-complete pulse
module proc_control
   import proc_pkg::*;
(
   input  logic                Clock,
   input  logic                Reset,
   input  logic                Run,
   input  logic [DATA_W-1:0]   IR,
   output logic                IRin,
   output logic [NUM_REGS-1:0] Rin,
   output logic [NUM_REGS-1:0] Rout,
   output logic                Gout,
   output logic                DIn_out,
   output logic                ones_out,
   output logic                Ain,
   output logic                Gin,
   output logic                AddSub,
   output logic                Done
);

   state_t                state_r;
   state_t                state_next_s;
   logic [2:0]            opcode_s;
   logic [NUM_REGS-1:0]   x_oh_s;
   logic [NUM_REGS-1:0]   y_oh_s;

   assign opcode_s = IR[8:6];

   dec3to8 u_dec_x (
      .sel    (IR[5:3]),
      .onehot (x_oh_s)
   );

   dec3to8 u_dec_y (
      .sel    (IR[2:0]),
      .onehot (y_oh_s)
   );

   // State register; reset abandons any instruction in flight.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state and output decode from state and IR.
   always_comb begin
      state_next_s = S_IDLE;
      IRin         = 1'b0;
      Rin          = {NUM_REGS{1'b0}};
      Rout         = {NUM_REGS{1'b0}};
      Gout         = 1'b0;
      DIn_out      = 1'b0;
      ones_out     = 1'b0;
      Ain          = 1'b0;
      Gin          = 1'b0;
      AddSub       = 1'b0;
      Done         = 1'b0;
      case (state_r)
         S_IDLE: begin
            IRin = Run;
            if (Run) begin
               state_next_s = S_T1;
            end else begin
               state_next_s = S_IDLE;
            end
         end
         S_T1: begin
            case (opcode_s)
               OP_MV: begin
                  Rout = y_oh_s;
                  Rin  = x_oh_s;
                  Done = 1'b1;
                  state_next_s = S_IDLE;
               end
               OP_MVI: begin
                  DIn_out = 1'b1;
                  Rin     = x_oh_s;
                  Done    = 1'b1;
                  state_next_s = S_IDLE;
               end
               OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
                  Rout = x_oh_s;
                  Ain  = 1'b1;
                  state_next_s = S_T2;
               end
               default: begin
                  // Reserved opcodes complete immediately as a no-op.
                  Done = 1'b1;
                  state_next_s = S_IDLE;
               end
            endcase
         end
         S_T2: begin
            Gin = 1'b1;
            state_next_s = S_T3;
            case (opcode_s)
               OP_INC: begin
                  ones_out = 1'b1;
               end
               OP_DEC: begin
                  ones_out = 1'b1;
                  AddSub   = 1'b1;
               end
               OP_SUB: begin
                  Rout   = y_oh_s;
                  AddSub = 1'b1;
               end
               default: begin
                  Rout = y_oh_s;
               end
            endcase
         end
         S_T3: begin
            Gout = 1'b1;
            Rin  = x_oh_s;
            Done = 1'b1;
            state_next_s = S_IDLE;
         end
         default: begin
            state_next_s = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_proc_control.sv
// tb_proc_control: directed plus randomized checks of proc_control against
// a per-instruction expected-output sequence built from the opcode rules.
module tb_proc_control;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       Run;
   logic [8:0] ir_q = 9'd0;
   logic [8:0] instr_src;
   logic       IRin;
   logic [7:0] Rin;
   logic [7:0] Rout;
   logic       Gout, DIn_out, ones_out, Ain, Gin, AddSub, Done;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int rin_count = 0;
   int done_cycles[$];

   localparam logic [7:0] Z8 = 8'h00;

   proc_control dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Run      (Run),
      .IR       (ir_q),
      .IRin     (IRin),
      .Rin      (Rin),
      .Rout     (Rout),
      .Gout     (Gout),
      .DIn_out  (DIn_out),
      .ones_out (ones_out),
      .Ain      (Ain),
      .Gin      (Gin),
      .AddSub   (AddSub),
      .Done     (Done)
   );

   always #5 Clock = ~Clock;

   // Cycle counter.
   always @(posedge Clock) cyc <= cyc + 1;

   // External IR register loaded from the instruction source.
   always @(posedge Clock) begin
      if (IRin) ir_q <= instr_src;
   end

   // Record every Rin pulse and every Done cycle.
   always @(negedge Clock) begin
      if (Rin != 8'h00) rin_count <= rin_count + 1;
      if (Done) done_cycles.push_back(cyc);
   end

   logic [23:0] obs_s;
   assign obs_s = {IRin, Rin, Rout, Gout, DIn_out, ones_out, Ain, Gin, AddSub, Done};

   function automatic logic [23:0] pk(logic irin, logic [7:0] rin, logic [7:0] rout,
                                      logic gout, logic din, logic ones, logic ain,
                                      logic gin, logic addsub, logic done);
      return {irin, rin, rout, gout, din, ones, ain, gin, addsub, done};
   endfunction

   function automatic bit is_arith(logic [8:0] ir);
      int op = int'(ir[8:6]);
      return (op >= 2) && (op <= 5);
   endfunction

   // Expected outputs for execution step k (0 = first cycle after accept).
   function automatic logic [23:0] exp_vec(logic [8:0] ir, int k);
      int op = int'(ir[8:6]);
      logic [7:0] one = 8'd1;
      logic [7:0] xo = one << ir[5:3];
      logic [7:0] yo = one << ir[2:0];
      logic minus = (op == 3) || (op == 5);
      if (k == 0) begin
         if (op == 0) return pk(1'b0, xo, yo, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         if (op == 1) return pk(1'b0, xo, Z8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         if (is_arith(ir)) return pk(1'b0, Z8, xo, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         return pk(1'b0, Z8, Z8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      if (k == 1) begin
         if (op >= 4) return pk(1'b0, Z8, Z8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, minus, 1'b0);
         return pk(1'b0, Z8, yo, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, minus, 1'b0);
      end
      return pk(1'b0, xo, Z8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endfunction

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Compare outputs at the falling edge, plus bus-select exclusivity.
   task automatic chk(input string tag, input logic [23:0] exp);
      int nsel;
      @(negedge Clock);
      vectors++;
      assert (obs_s === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h (IR=%b)", tag, obs_s, exp, ir_q);
      end
      nsel = $countones(Rout) + int'(Gout) + int'(DIn_out) + int'(ones_out);
      vectors++;
      assert (nsel <= 1) else begin
         miscompares++;
         $error("FAIL %s_busx: observed %0d bus selects expected at most 1", tag, nsel);
      end
   endtask

   task automatic fetch(input logic [8:0] ir);
      instr_src = ir;
      Run = 1'b1;
      chk("fetch", pk(1'b1, Z8, Z8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      tick();
   endtask

   // Fetch and execute one instruction, checking every cycle against the model.
   task automatic do_instr(input logic [8:0] ir, input bit hold);
      int n = is_arith(ir) ? 3 : 1;
      fetch(ir);
      for (int k = 0; k < n; k++) begin
         Run = hold ? 1'b1 : 1'($urandom_range(0, 1));
         chk("exec", exp_vec(ir, k));
         tick();
      end
   endtask

   initial begin
      int rin_before;
      int c0;
      int ndone;
      logic [8:0] rir;
      logic [23:0] zero_v;
      zero_v = 24'd0;
      Reset = 1'b1;
      Run = 1'b0;
      instr_src = 9'd0;
      tick();
      tick();
      chk("reset_hold", zero_v);
      Reset = 1'b0;
      tick();
      chk("reset_idle", zero_v);
      tick();

      // mv R2,R5
      fetch(9'b000_010_101);
      Run = 1'b0;
      chk("mv_t1", pk(1'b0, 8'b00000100, 8'b00100000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      tick();
      chk("mv_after", zero_v);
      tick();

      // mvi R7
      fetch(9'b001_111_000);
      Run = 1'b0;
      chk("mvi_t1", pk(1'b0, 8'b10000000, Z8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      tick();

      // sub R1,R3 with Run toggling during execution
      fetch(9'b011_001_011);
      Run = 1'b1;
      chk("sub_t1", pk(1'b0, Z8, 8'b00000010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      tick();
      chk("sub_t2", pk(1'b0, Z8, 8'b00001000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
      tick();
      chk("sub_t3", pk(1'b0, 8'b00000010, Z8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      Run = 1'b0;
      tick();

      // inc R0
      fetch(9'b100_000_000);
      Run = 1'b0;
      chk("inc_t1", pk(1'b0, Z8, 8'b00000001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      tick();
      chk("inc_t2", pk(1'b0, Z8, Z8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
      tick();
      chk("inc_t3", pk(1'b0, 8'b00000001, Z8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      tick();

      // Reset in T2 of add R4,R6
      rin_before = rin_count;
      fetch(9'b010_100_110);
      Run = 1'b0;
      chk("add_t1", pk(1'b0, Z8, 8'b00010000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      tick();
      chk("add_t2", pk(1'b0, Z8, 8'b01000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("rst_mid_idle", zero_v);
      tick();
      chk("rst_mid_idle2", zero_v);
      tick();
      chk("rst_mid_idle3", zero_v);
      vectors++;
      assert (rin_count === rin_before) else begin
         miscompares++;
         $error("FAIL rst_no_rin: observed %0d Rin pulses expected 0", rin_count - rin_before);
      end
      tick();

      // Run held over add then reserved 111: Done 3 and 5 cycles after accept
      ndone = done_cycles.size();
      @(negedge Clock);
      c0 = cyc;
      tick();
      do_instr(9'b010_011_101, 1'b1);
      do_instr(9'b111_000_000, 1'b1);
      Run = 1'b0;
      chk("held_idle", zero_v);
      vectors++;
      assert (done_cycles.size() === ndone + 2) else begin
         miscompares++;
         $error("FAIL held_done_n: observed %0d Done pulses expected 2", done_cycles.size() - ndone);
      end
      if (done_cycles.size() >= ndone + 2) begin
         vectors++;
         assert (done_cycles[ndone] === c0 + 4) else begin
            miscompares++;
            $error("FAIL held_done1: observed cycle %0d expected %0d", done_cycles[ndone] - c0 - 1, 3);
         end
         vectors++;
         assert (done_cycles[ndone + 1] === c0 + 6) else begin
            miscompares++;
            $error("FAIL held_done2: observed cycle %0d expected %0d", done_cycles[ndone + 1] - c0 - 1, 5);
         end
      end
      tick();

      // Randomized instruction stream
      for (int i = 0; i < 60; i++) begin
         rir = 9'($urandom_range(0, 511));
         do_instr(rir, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) begin
            Run = 1'b0;
            instr_src = 9'($urandom_range(0, 511));
            chk("rand_idle", zero_v);
            tick();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/proc_control.md
PROC_CONTROL -- requirements
Module: proc_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows.
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset.
REQ-002 The block SHALL have the following ports.
- Run  in  1  start request, sampled only in IDLE.
- IR  in  9  instruction {III opcode, XXX dest/src1, YYY src2}, held stable by the IR register from T1 through T3.
- IRin  out  1  IR register load enable.
- Rin  out  8  one-hot register write enables; bit n selects Rn.
- Rout  out  8  one-hot bus select for R0..R7, matching the bus mux encoding.
- Gout  out  1  bus select for G.
- DIn_out  out  1  bus select for DIn.
- ones_out  out  1  bus select for the constant-ones operand.
- Ain  out  1  A register load enable.
- Gin  out  1  G register load enable.
- AddSub  out  1  ALU operation; 0 = A+Bus, 1 = A-Bus.
- Done  out  1  single-cycle instruction-complete pulse.

Function
REQ-003 The FSM SHALL have states IDLE, T1, T2 and T3; all outputs SHALL be decoded combinationally from the state and IR.
REQ-004 In IDLE the block SHALL assert IRin=Run, move to T1 when Run=1, and otherwise stay in IDLE.
REQ-005 Opcodes SHALL be: 000 mv, 001 mvi, 010 add, 011 sub, 100 inc, 101 dec, 110/111 reserved.
REQ-006 T1 SHALL behave per opcode:
- mv: Rout=onehot(YYY), Rin=onehot(XXX), Done=1, then IDLE.
- mvi: DIn_out=1, Rin=onehot(XXX), Done=1, then IDLE.
- add/sub/inc/dec: Rout=onehot(XXX), Ain=1, then T2.
- reserved: Done=1 only, then IDLE.
REQ-007 T2 SHALL behave per opcode, then go to T3:
- add/sub: Rout=onehot(YYY), Gin=1.
- inc/dec: ones_out=1, Gin=1.
- AddSub SHALL be 1 for sub/dec and 0 otherwise.
REQ-008 T3 SHALL assert Gout=1, Rin=onehot(XXX) and Done=1, then go to IDLE.
REQ-009 In every cycle at most one of {any Rout bit, Gout, DIn_out, ones_out} SHALL be asserted, and Rout SHALL be one-hot or zero.
REQ-010 All outputs not listed for the current state/opcode SHALL be 0; this includes every output in IDLE except IRin.
REQ-011 Run SHALL be ignored in T1..T3.
REQ-012 With Run held at 1, the next fetch SHALL begin in the cycle after Done, i.e. IDLE is visited for exactly one cycle.
REQ-013 Latency from the Run-accepting edge SHALL be:
- mv, mvi and reserved: Done in the 1st following cycle.
- add, sub, inc and dec: Done in the 3rd following cycle.
REQ-014 When XXX equals YYY, Rout and Rin SHALL select the same register without special handling.

Reset
REQ-015 When Reset=1 at a rising edge, the state SHALL become IDLE, overriding all other inputs, including mid-instruction.
REQ-016 While in IDLE after reset, with Run=0, all outputs SHALL be 0.
REQ-017 A partially executed instruction SHALL not be completed after reset and SHALL produce no Rin pulse.

Structure
REQ-018 Package proc_pkg SHALL hold the opcode constants, the state encoding, and the register-count/width constants (8 registers, 9-bit data).
REQ-019 A sub-module dec3to8 SHALL perform the 3-bit to 8-bit one-hot decode and SHALL be instantiated for XXX and for YYY.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- mv R2,R5: IR=000_010_101, Run pulse -> T1: Rout=8'b00100000, Rin=8'b00000100, Done=1; next cycle all outputs 0.
- mvi R7: IR=001_111_000 -> T1: DIn_out=1, Rin=8'b10000000, Done=1.
- sub R1,R3: IR=011_001_011 -> T1: Rout=8'b00000010, Ain=1; T2: Rout=8'b00001000, Gin=1, AddSub=1; T3: Gout=1, Rin=8'b00000010, Done=1.
- inc R0: IR=100_000_000 -> T2: ones_out=1, Gin=1, AddSub=0; T3: Rin=8'b00000001, Done=1.
- Reset asserted in T2 of add R4,R6 -> next cycle IDLE, all outputs 0, no Rin pulse ever observed.
- Run held at 1 over add then reserved 111 -> Done at cycles 3 and 5 after first accept; per-cycle assertion that bus selects stay mutually exclusive.
